// File: rtl/rob_retire.sv
// In-order retirement buffer: program-order allocation, out-of-order completion,
// and retirement of up to two completed head entries per cycle into the ARF.
module rob_retire #(
    parameter int ROB_DEPTH = 16,
    parameter int ROB_IDX   = 4,
    parameter int AR_SIZE   = 6
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               alloc_valid,
    input  logic               alloc_has_dest,
    input  logic [AR_SIZE-1:0] alloc_ar,
    output logic               alloc_ready,
    output logic [ROB_IDX-1:0] alloc_idx,
    input  logic               cmpl_valid,
    input  logic [ROB_IDX-1:0] cmpl_idx,
    input  logic [31:0]        cmpl_data,
    input  logic               flush,
    output logic [AR_SIZE-1:0] arf_write_addr1,
    output logic [31:0]        arf_write_data1,
    output logic [AR_SIZE-1:0] arf_write_addr2,
    output logic [31:0]        arf_write_data2,
    output logic               arf_write_en,
    output logic [1:0]         retire_cnt,
    output logic [ROB_IDX:0]   rob_count
);

    logic [ROB_DEPTH-1:0] r_valid;
    logic [ROB_DEPTH-1:0] r_done;
    logic [ROB_DEPTH-1:0] r_has_dest;
    logic [AR_SIZE-1:0]   r_ar   [ROB_DEPTH];
    logic [31:0]          r_data [ROB_DEPTH];
    logic [ROB_IDX-1:0]   r_head;
    logic [ROB_IDX-1:0]   r_tail;
    logic [ROB_IDX:0]     r_count;

    logic [AR_SIZE-1:0]   r_addr1_p1;
    logic [31:0]          r_data1_p1;
    logic [AR_SIZE-1:0]   r_addr2_p1;
    logic [31:0]          r_data2_p1;
    logic                 r_vld_p1;
    logic [1:0]           r_cnt_p1;

    logic                 w_alloc_fire;
    logic                 w_cmpl_fire;
    logic [ROB_IDX-1:0]   w_head1;
    logic                 w_r0;
    logic                 w_r1;
    logic [1:0]           w_retire_cnt;
    logic [AR_SIZE-1:0]   w_addr1;
    logic [31:0]          w_data1;
    logic [AR_SIZE-1:0]   w_addr2;
    logic [31:0]          w_data2;

    // A retiring slot without a destination, or an unused slot, writes register 0 with 0.
    function automatic logic [AR_SIZE-1:0] slot_addr(input logic en, input logic [AR_SIZE-1:0] ar);
        return en ? ar : '0;
    endfunction

    function automatic logic [31:0] slot_data(input logic en, input logic [31:0] d);
        return en ? d : 32'd0;
    endfunction

    // Full is bit ROB_IDX of the count, so a same-cycle retire never frees a slot early.
    assign alloc_ready  = ~r_count[ROB_IDX];
    assign alloc_idx    = r_tail;
    assign rob_count    = r_count;

    assign w_alloc_fire = alloc_valid & alloc_ready;
    assign w_cmpl_fire  = cmpl_valid & r_valid[cmpl_idx];
    assign w_head1      = r_head + {{(ROB_IDX-1){1'b0}}, 1'b1};

    // Stage p0: retire decision from registered state only
    assign w_r0         = r_valid[r_head] & r_done[r_head];
    assign w_r1         = w_r0 & r_valid[w_head1] & r_done[w_head1];
    assign w_retire_cnt = {w_r1, w_r0 & ~w_r1};

    assign w_addr1 = slot_addr(w_r0 & r_has_dest[r_head], r_ar[r_head]);
    assign w_data1 = slot_data(w_r0 & r_has_dest[r_head], r_data[r_head]);
    assign w_addr2 = slot_addr(w_r1 & r_has_dest[w_head1], r_ar[w_head1]);
    assign w_data2 = slot_data(w_r1 & r_has_dest[w_head1], r_data[w_head1]);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_valid <= '0;
            r_done  <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_valid <= '0;
            r_done  <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_cmpl_fire)
                r_done[cmpl_idx] <= 1'b1;
            // Retire clears win over a completion landing on the same entry.
            if (w_r0) begin
                r_valid[r_head] <= 1'b0;
                r_done[r_head]  <= 1'b0;
            end
            if (w_r1) begin
                r_valid[w_head1] <= 1'b0;
                r_done[w_head1]  <= 1'b0;
            end
            if (w_alloc_fire) begin
                r_valid[r_tail] <= 1'b1;
                r_done[r_tail]  <= 1'b0;
                r_tail          <= r_tail + {{(ROB_IDX-1){1'b0}}, 1'b1};
            end
            r_head  <= r_head + {{(ROB_IDX-2){1'b0}}, w_retire_cnt};
            r_count <= r_count + {{ROB_IDX{1'b0}}, w_alloc_fire}
                               - {{(ROB_IDX-1){1'b0}}, w_retire_cnt};
        end
    end

    // Payload storage is qualified by valid/done, so it needs no reset.
    always_ff @(posedge clk) begin
        if (w_cmpl_fire)
            r_data[cmpl_idx] <= cmpl_data;
        if (w_alloc_fire) begin
            r_has_dest[r_tail] <= alloc_has_dest;
            r_ar[r_tail]       <= alloc_ar;
        end
    end

    // Stage p1: registered ARF write port, held for one cycle
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_addr1_p1 <= '0;
            r_data1_p1 <= '0;
            r_addr2_p1 <= '0;
            r_data2_p1 <= '0;
            r_vld_p1   <= 1'b0;
            r_cnt_p1   <= '0;
        end else if (flush) begin
            r_addr1_p1 <= '0;
            r_data1_p1 <= '0;
            r_addr2_p1 <= '0;
            r_data2_p1 <= '0;
            r_vld_p1   <= 1'b0;
            r_cnt_p1   <= '0;
        end else begin
            r_addr1_p1 <= w_addr1;
            r_data1_p1 <= w_data1;
            r_addr2_p1 <= w_addr2;
            r_data2_p1 <= w_data2;
            r_vld_p1   <= w_r0;
            r_cnt_p1   <= w_retire_cnt;
        end
    end

    assign arf_write_addr1 = r_addr1_p1;
    assign arf_write_data1 = r_data1_p1;
    assign arf_write_addr2 = r_addr2_p1;
    assign arf_write_data2 = r_data2_p1;
    assign arf_write_en    = r_vld_p1;
    assign retire_cnt      = r_cnt_p1;

endmodule

// File: tb/tb_rob_retire.sv
// Self-checking bench for rob_retire: directed vector table, hand-written corner
// sequences and randomized traffic against a queue-based program-order model.
module tb_rob_retire;

    logic        clk = 1'b0;
    logic        rstn;
    logic        alloc_valid, alloc_has_dest;
    logic [5:0]  alloc_ar;
    logic        alloc_ready;
    logic [3:0]  alloc_idx;
    logic        cmpl_valid;
    logic [3:0]  cmpl_idx;
    logic [31:0] cmpl_data;
    logic        flush;
    logic [5:0]  a1, a2;
    logic [31:0] d1, d2;
    logic        we;
    logic [1:0]  rc;
    logic [4:0]  rob_count;

    int errors = 0;
    int checks = 0;

    rob_retire #(.ROB_DEPTH(16), .ROB_IDX(4), .AR_SIZE(6)) dut (
        .clk(clk), .rstn(rstn),
        .alloc_valid(alloc_valid), .alloc_has_dest(alloc_has_dest), .alloc_ar(alloc_ar),
        .alloc_ready(alloc_ready), .alloc_idx(alloc_idx),
        .cmpl_valid(cmpl_valid), .cmpl_idx(cmpl_idx), .cmpl_data(cmpl_data),
        .flush(flush),
        .arf_write_addr1(a1), .arf_write_data1(d1),
        .arf_write_addr2(a2), .arf_write_data2(d2),
        .arf_write_en(we), .retire_cnt(rc), .rob_count(rob_count)
    );

    always #5 clk = ~clk;

    // Reference model: the ROB as a program-ordered queue of in-flight instructions.
    typedef struct {
        logic [3:0]  tag;
        logic        hd;
        logic [5:0]  ar;
        logic        done;
        logic [31:0] data;
    } ent_t;
    ent_t mq[$];
    int   m_tail;

    logic        e_we;
    logic [1:0]  e_rc;
    logic [5:0]  e_a1, e_a2;
    logic [31:0] e_d1, e_d2;

    typedef struct {
        logic        av, hd;
        logic [5:0]  ar;
        logic        cv;
        logic [3:0]  ci;
        logic [31:0] cd;
        logic        fl;
        logic        we;
        logic [1:0]  rc;
        logic [5:0]  a1;
        logic [31:0] d1;
        logic [5:0]  a2;
        logic [31:0] d2;
        logic [4:0]  cnt;
    } vec_t;
    vec_t tbl[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_tail = 0;
    endtask

    task automatic model_cycle(input logic av, hd, input logic [5:0] ar, input logic cv,
                               input logic [3:0] ci, input logic [31:0] cd, input logic fl);
        int n, pre;
        ent_t e;
        e_we = 0; e_rc = 0; e_a1 = 0; e_d1 = 0; e_a2 = 0; e_d2 = 0;
        if (fl) begin
            model_clear();
            return;
        end
        pre = mq.size();
        n = 0;
        if (pre >= 1 && mq[0].done) n = 1;
        if (n == 1 && pre >= 2 && mq[1].done) n = 2;
        if (n >= 1) begin
            e_we = 1;
            if (mq[0].hd) begin e_a1 = mq[0].ar; e_d1 = mq[0].data; end
        end
        if (n == 2 && mq[1].hd) begin e_a2 = mq[1].ar; e_d2 = mq[1].data; end
        e_rc = 2'(n);
        if (cv)
            foreach (mq[i])
                if (mq[i].tag == ci) begin mq[i].done = 1; mq[i].data = cd; end
        for (int k = 0; k < n; k++) void'(mq.pop_front());
        if (av && pre < 16) begin
            e.tag = 4'(m_tail); e.hd = hd; e.ar = ar; e.done = 0; e.data = 0;
            mq.push_back(e);
            m_tail = (m_tail + 1) % 16;
        end
    endtask

    task automatic step(input logic av, hd, input logic [5:0] ar, input logic cv,
                        input logic [3:0] ci, input logic [31:0] cd, input logic fl);
        alloc_valid = av; alloc_has_dest = hd; alloc_ar = ar;
        cmpl_valid = cv; cmpl_idx = ci; cmpl_data = cd; flush = fl;
        model_cycle(av, hd, ar, cv, ci, cd, fl);
        @(posedge clk);
        #1;
        chk("we", 32'(we), 32'(e_we));
        chk("retire_cnt", 32'(rc), 32'(e_rc));
        chk("addr1", 32'(a1), 32'(e_a1));
        chk("data1", d1, e_d1);
        chk("addr2", 32'(a2), 32'(e_a2));
        chk("data2", d2, e_d2);
        chk("rob_count", 32'(rob_count), 32'(mq.size()));
        chk("alloc_ready", 32'(alloc_ready), 32'(mq.size() < 16));
        chk("alloc_idx", 32'(alloc_idx), 32'(m_tail));
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        alloc_valid = 0; alloc_has_dest = 0; alloc_ar = 0;
        cmpl_valid = 0; cmpl_idx = 0; cmpl_data = 0; flush = 0;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        do_reset();
        chk("reset_alloc_ready", 32'(alloc_ready), 32'd1);
        chk("reset_rob_count", 32'(rob_count), 32'd0);
        chk("reset_we", 32'(we), 32'd0);
        chk("reset_addr_data", {a1, a2, d1[9:0], d2[9:0]}, 32'd0);
        step(0, 0, 0, 0, 0, 0, 0);

        //              av hd ar  cv ci  cd           fl  we rc a1 d1           a2 d2           cnt
        tbl[0]  = '{1, 1, 5,  0, 0, 32'h0,      0,  0, 0, 0, 32'h0,      0, 32'h0,      1};
        tbl[1]  = '{1, 1, 7,  0, 0, 32'h0,      0,  0, 0, 0, 32'h0,      0, 32'h0,      2};
        tbl[2]  = '{0, 0, 0,  1, 1, 32'hBBBB,   0,  0, 0, 0, 32'h0,      0, 32'h0,      2};
        tbl[3]  = '{0, 0, 0,  0, 0, 32'h0,      0,  0, 0, 0, 32'h0,      0, 32'h0,      2};
        tbl[4]  = '{0, 0, 0,  1, 0, 32'hAAAA,   0,  0, 0, 0, 32'h0,      0, 32'h0,      2};
        tbl[5]  = '{0, 0, 0,  0, 0, 32'h0,      0,  1, 2, 5, 32'hAAAA,   7, 32'hBBBB,   0};
        tbl[6]  = '{0, 0, 0,  0, 0, 32'h0,      0,  0, 0, 0, 32'h0,      0, 32'h0,      0};
        tbl[7]  = '{1, 0, 9,  0, 0, 32'h0,      0,  0, 0, 0, 32'h0,      0, 32'h0,      1};
        tbl[8]  = '{0, 0, 0,  1, 2, 32'h1234,   0,  0, 0, 0, 32'h0,      0, 32'h0,      1};
        tbl[9]  = '{0, 0, 0,  0, 0, 32'h0,      0,  1, 1, 0, 32'h0,      0, 32'h0,      0};
        tbl[10] = '{1, 1, 3,  0, 0, 32'h0,      0,  0, 0, 0, 32'h0,      0, 32'h0,      1};
        tbl[11] = '{1, 1, 3,  0, 0, 32'h0,      0,  0, 0, 0, 32'h0,      0, 32'h0,      2};
        tbl[12] = '{0, 0, 0,  1, 4, 32'h2,      0,  0, 0, 0, 32'h0,      0, 32'h0,      2};
        tbl[13] = '{0, 0, 0,  1, 3, 32'h1,      0,  0, 0, 0, 32'h0,      0, 32'h0,      2};
        tbl[14] = '{0, 0, 0,  0, 0, 32'h0,      0,  1, 2, 3, 32'h1,      3, 32'h2,      0};
        tbl[15] = '{0, 0, 0,  0, 0, 32'h0,      0,  0, 0, 0, 32'h0,      0, 32'h0,      0};
        for (int i = 0; i < 16; i++) begin
            step(tbl[i].av, tbl[i].hd, tbl[i].ar, tbl[i].cv, tbl[i].ci, tbl[i].cd, tbl[i].fl);
            chk($sformatf("tbl%0d_we", i), 32'(we), 32'(tbl[i].we));
            chk($sformatf("tbl%0d_rc", i), 32'(rc), 32'(tbl[i].rc));
            chk($sformatf("tbl%0d_a1", i), 32'(a1), 32'(tbl[i].a1));
            chk($sformatf("tbl%0d_d1", i), d1, tbl[i].d1);
            chk($sformatf("tbl%0d_a2", i), 32'(a2), 32'(tbl[i].a2));
            chk($sformatf("tbl%0d_d2", i), d2, tbl[i].d2);
            chk($sformatf("tbl%0d_cnt", i), 32'(rob_count), 32'(tbl[i].cnt));
        end

        // Fill to capacity starting at tag 5, so the tail wraps through 0.
        for (int i = 0; i < 16; i++) begin
            step(1, 1, 6'(20 + i), 0, 0, 0, 0);
            if (i == 10) chk("wrap_alloc_idx", 32'(alloc_idx), 32'd0);
        end
        chk("full_alloc_ready", 32'(alloc_ready), 32'd0);
        step(1, 1, 6'd40, 0, 0, 0, 0);
        chk("full_ignore_count", 32'(rob_count), 32'd16);
        step(1, 1, 6'd41, 1, 4'd5, 32'hC0DE, 0);
        chk("full_cmpl_count", 32'(rob_count), 32'd16);
        step(1, 1, 6'd42, 0, 0, 0, 0);
        chk("full_retire_refuse", 32'(rob_count), 32'd15);
        chk("full_retire_data", d1, 32'hC0DE);
        chk("full_ready_again", 32'(alloc_ready), 32'd1);
        step(1, 1, 6'd43, 0, 0, 0, 0);
        chk("refill_count", 32'(rob_count), 32'd16);

        // Flush with partial completion and a same-cycle completion.
        step(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) step(1, 1, 6'(50 + i), 0, 0, 0, 0);
        step(0, 0, 0, 1, 4'd2, 32'h22, 0);
        step(0, 0, 0, 1, 4'd3, 32'h33, 0);
        step(0, 0, 0, 1, 4'd0, 32'h11, 1);
        chk("flush_count", 32'(rob_count), 32'd0);
        chk("flush_we", 32'(we), 32'd0);
        step(0, 0, 0, 1, 4'd1, 32'h44, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("flushed_cmpl_ignored", 32'(we), 32'd0);
        step(1, 1, 6'd60, 1, 4'd0, 32'h55, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("same_cycle_cmpl_ignored", 32'(rob_count), 32'd1);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            logic av, hd, cv, fl;
            logic [3:0] ci;
            av = ($urandom_range(0, 99) < (((i / 100) % 2) ? 85 : 35));
            hd = ($urandom_range(0, 3) != 0);
            cv = ($urandom_range(0, 99) < 60);
            if (mq.size() > 0 && $urandom_range(0, 9) < 8)
                ci = mq[$urandom_range(0, mq.size() - 1)].tag;
            else
                ci = 4'($urandom_range(0, 15));
            fl = ($urandom_range(0, 99) == 0);
            step(av, hd, 6'($urandom_range(0, 63)), cv, ci, $urandom, fl);
        end

        // Asynchronous reset while retire outputs are active.
        do_reset();
        step(1, 1, 6'd10, 0, 0, 0, 0);
        step(1, 1, 6'd11, 0, 0, 0, 0);
        step(0, 0, 0, 1, 4'd0, 32'hDEAD, 0);
        step(0, 0, 0, 1, 4'd1, 32'hBEEF, 0);
        chk("pre_reset_we", 32'(we), 32'd1);
        rstn = 1'b0;
        #1;
        chk("async_we", 32'(we), 32'd0);
        chk("async_rc", 32'(rc), 32'd0);
        chk("async_a1", 32'(a1), 32'd0);
        chk("async_d1", d1, 32'd0);
        chk("async_count", 32'(rob_count), 32'd0);
        chk("async_ready", 32'(alloc_ready), 32'd1);
        model_clear();
        @(negedge clk);
        rstn = 1'b1;
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
